// File: rtl/fifo_ram_wxd_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_ram_wxd (slave).
// Widths track the FIFO word width and log2 depth.
interface fifo_ram_wxd_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
);
  logic                  clr;
  logic                  we;
  logic [DATA_WIDTH-1:0] din;
  logic                  re;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DATA_DEPTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, we, din, re,
    input  dout, dvalid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  clr, we, din, re,
    output dout, dvalid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram_wxd.sv
// Synchronous FIFO on a distributed-RAM array with registered occupancy flags,
// sticky overflow/underflow, and either first-word-fall-through or registered output.
module fifo_ram_wxd #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4,
  parameter int AF_LEVEL   = (1 << DATA_DEPTH) - 2,
  parameter int AE_LEVEL   = 1,
  parameter bit OREG       = 1'b0
) (
  input logic            clk,
  input logic            rst,
  fifo_ram_wxd_if.slave  bus
);

  localparam int CAPACITY = 1 << DATA_DEPTH;
  localparam logic [DATA_DEPTH:0]   LEVEL_FULL = (DATA_DEPTH+1)'(CAPACITY);
  localparam logic [DATA_DEPTH:0]   LEVEL_ONE  = (DATA_DEPTH+1)'(1);
  localparam logic [DATA_DEPTH-1:0] PTR_ONE    = DATA_DEPTH'(1);

  logic [DATA_WIDTH-1:0] mem [CAPACITY];

  logic [DATA_DEPTH-1:0] wr_ptr_reg;
  logic [DATA_DEPTH-1:0] rd_ptr_reg;
  logic [DATA_DEPTH:0]   level_reg;
  logic [DATA_DEPTH:0]   level_next;
  logic                  empty_reg;
  logic                  full_reg;
  logic                  af_reg;
  logic                  ae_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  ra;
  logic                  wa;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign ra = bus.re & ~empty_reg;
  assign wa = bus.we & (~full_reg | ra);

  always_comb begin
    level_next = level_reg;
    if (wa && !ra) begin
      level_next = level_reg + LEVEL_ONE;
    end else if (ra && !wa) begin
      level_next = level_reg - LEVEL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wa && !bus.clr) begin
      mem[wr_ptr_reg] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      af_reg        <= 1'b0;
      ae_reg        <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      af_reg        <= 1'b0;
      ae_reg        <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wa) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (ra) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      // Flags come from the next level so they line up with level in the same cycle.
      level_reg     <= level_next;
      empty_reg     <= (level_next == '0);
      full_reg      <= (level_next == LEVEL_FULL);
      af_reg        <= (32'(level_next) >= AF_LEVEL);
      ae_reg        <= (32'(level_next) <= AE_LEVEL);
      overflow_reg  <= overflow_reg | (bus.we & ~wa);
      underflow_reg <= underflow_reg | (bus.re & empty_reg);
    end
  end

  assign bus.level        = level_reg;
  assign bus.empty        = empty_reg;
  assign bus.full         = full_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

  generate
    if (OREG == 1'b0) begin : g_fwft
      assign bus.dout   = mem[rd_ptr_reg];
      assign bus.dvalid = ~empty_reg;
    end else begin : g_oreg
      logic [DATA_WIDTH-1:0] dout_reg;
      logic                  dvalid_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_reg   <= '0;
          dvalid_reg <= 1'b0;
        end else if (bus.clr) begin
          dvalid_reg <= 1'b0;
        end else begin
          dvalid_reg <= ra;
          if (ra) begin
            dout_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign bus.dout   = dout_reg;
      assign bus.dvalid = dvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_ram_wxd.sv
// Directed bench for fifo_ram_wxd: FWFT instance checked against a queue model,
// registered-output instance exercised separately.
module tb_fifo_ram_wxd;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_ram_wxd_if #(.DATA_WIDTH(16), .DATA_DEPTH(4)) bus0 ();
  fifo_ram_wxd_if #(.DATA_WIDTH(16), .DATA_DEPTH(4)) bus1 ();

  fifo_ram_wxd #(.DATA_WIDTH(16), .DATA_DEPTH(4), .OREG(1'b0)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fifo_ram_wxd #(.DATA_WIDTH(16), .DATA_DEPTH(4), .OREG(1'b1)) u_oreg (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_level  = 0;
  bit          m_ov     = 1'b0;
  bit          m_un     = 1'b0;
  logic [15:0] q  [$];
  logic [15:0] q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(bus0.level), 32'(m_level));
    chk({tag, "_empty"}, 32'(bus0.empty), 32'(m_level == 0));
    chk({tag, "_full"}, 32'(bus0.full), 32'(m_level == 16));
    chk({tag, "_af"}, 32'(bus0.almost_full), 32'(m_level >= 14));
    chk({tag, "_ae"}, 32'(bus0.almost_empty), 32'(m_level <= 1));
    chk({tag, "_ovf"}, 32'(bus0.overflow), 32'(m_ov));
    chk({tag, "_unf"}, 32'(bus0.underflow), 32'(m_un));
    chk({tag, "_dvalid"}, 32'(bus0.dvalid), 32'(m_level != 0));
    if (m_level != 0) chk({tag, "_dout"}, 32'(bus0.dout), 32'(q[0]));
  endtask

  // One clock of FWFT stimulus; the displayed word is checked before the edge that consumes it.
  task automatic step(input string tag, input bit w, input logic [15:0] d, input bit r, input bit c);
    bit was_empty, ra, wa;
    bus0.we = w; bus0.din = d; bus0.re = r; bus0.clr = c;
    #1;
    was_empty = (m_level == 0);
    ra = r && !was_empty;
    wa = w && ((m_level < 16) || ra);
    if (c) begin
      q.delete();
      m_level = 0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      if (ra) begin
        chk({tag, "_rd"}, 32'(bus0.dout), 32'(q[0]));
        void'(q.pop_front());
      end
      if (wa) q.push_back(d);
      if (wa && !ra) m_level++;
      else if (ra && !wa) m_level--;
      if (w && !wa) m_ov = 1'b1;
      if (r && was_empty) m_un = 1'b1;
    end
    tick();
    bus0.we = 1'b0; bus0.re = 1'b0; bus0.clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    bus0.we = 1'b0; bus0.re = 1'b0; bus0.clr = 1'b0; bus0.din = '0;
    bus1.we = 1'b0; bus1.re = 1'b0; bus1.clr = 1'b0; bus1.din = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset_oreg_dout", 32'(bus1.dout), 32'h0);
    chk("reset_oreg_dvalid", 32'(bus1.dvalid), 32'h0);
    #2 rst = 1'b0;
    tick();

    // Fill with 1..16, then drain in order.
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Sustained simultaneous read/write at full, across pointer wrap.
    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("rw_full", 1'b1, 16'(16'h0200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 16'h0, 1'b1, 1'b0);

    // Overflow: dropped write, sticky until clr.
    for (int i = 0; i < 16; i++) step("fill3", 1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    step("ovf", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("drain3", 1'b0, 16'h0, 1'b1, 1'b0);
    step("clr_ovf", 1'b0, 16'h0, 1'b0, 1'b1);

    // Underflow with a same-cycle write into the empty FIFO.
    step("unf", 1'b1, 16'hA5A5, 1'b1, 1'b0);
    step("unf_rd", 1'b0, 16'h0, 1'b1, 1'b0);
    step("clr_unf", 1'b0, 16'h0, 1'b0, 1'b1);

    // Registered-output instance.
    bus1.we = 1'b1; bus1.din = 16'h1234; q1.push_back(16'h1234);
    tick();
    bus1.we = 1'b0;
    chk("oreg_wr_dvalid", 32'(bus1.dvalid), 32'h0);
    chk("oreg_wr_level", 32'(bus1.level), 32'h1);
    tick();
    bus1.re = 1'b1;
    tick();
    bus1.re = 1'b0;
    chk("oreg_rd_dvalid", 32'(bus1.dvalid), 32'h1);
    if (bus1.dvalid === 1'b1 && q1.size() > 0) chk("oreg_rd_dout", 32'(bus1.dout), 32'(q1.pop_front()));
    tick();
    chk("oreg_hold_dvalid", 32'(bus1.dvalid), 32'h0);
    chk("oreg_hold_dout", 32'(bus1.dout), 32'h1234);
    chk("oreg_empty", 32'(bus1.empty), 32'h1);

    // Asynchronous reset between edges while holding data.
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_level = 0; m_ov = 1'b0; m_un = 1'b0;
    check_state("async_rst");
    chk("async_rst_oreg_dout", 32'(bus1.dout), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    step("post_rst_wr", 1'b1, 16'h00FF, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 16'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ram_wxd.md
FIFO_RAM_WXD -- requirements
Module: fifo_ram_wxd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 4: log2 of entry count; capacity is 2^DATA_DEPTH words.
REQ-003 SHALL have parameter AF_LEVEL, default 2^DATA_DEPTH-2: almost_full asserts when level >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts when level <= AE_LEVEL.
REQ-005 SHALL have parameter OREG, default 0: 0 = first-word-fall-through (FWFT); 1 = registered read (standard).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1, the single clock, all state on its rising edge; rst input 1, asynchronous active-high reset.
REQ-007 clr input 1: synchronous flush, empties the FIFO.
REQ-008 we input 1: write request.
REQ-009 din input DATA_WIDTH: write data.
REQ-010 re input 1: read request.
REQ-011 dout output DATA_WIDTH: read data.
REQ-012 dvalid output 1: dout holds a valid word.
REQ-013 full, empty output 1 each: occupancy flags.
REQ-014 almost_full, almost_empty output 1 each: threshold flags.
REQ-015 level output DATA_DEPTH+1: current word count, 0..2^DATA_DEPTH.
REQ-016 overflow, underflow output 1 each: sticky error flags.

Function
REQ-017 Storage SHALL be a 2^DATA_DEPTH x DATA_WIDTH dual-port array with write on the rising clk edge and asynchronous read, mappable to distributed RAM; no reset on array contents.
REQ-018 Write/read pointers SHALL be DATA_DEPTH bits and wrap modulo 2^DATA_DEPTH with no extra logic.
REQ-019 Write accepted (wa) = we & (!full | ra); read accepted (ra) = re & !empty.
REQ-020 On wa, din SHALL be stored at the write pointer and the write pointer SHALL increment.
REQ-021 On ra, the read pointer SHALL increment.
REQ-022 level SHALL change by +1 on wa only, -1 on ra only, and stay unchanged on wa & ra, all in one cycle.
REQ-023 empty = (level==0); full = (level==2^DATA_DEPTH); almost_full and almost_empty SHALL be registered, consistent with level in the same cycle.
REQ-024 OREG=0: dout = array[read pointer] combinationally; dvalid = !empty; re acts as acknowledge of the displayed word; write-to-dout latency 1 cycle.
REQ-025 OREG=1: on ra, dout SHALL register array[read pointer] at the next edge and dvalid SHALL pulse high for exactly that one cycle; dout SHALL hold its value otherwise; write-to-dout latency 2 cycles minimum.
REQ-026 Write while full with no accepted read SHALL be dropped and SHALL set overflow.
REQ-027 Read while empty SHALL be ignored and SHALL set underflow, including when a write arrives in the same cycle; the new word becomes visible next cycle.
REQ-028 Write and read in the same cycle while full SHALL both be accepted; level SHALL stay at 2^DATA_DEPTH and overflow SHALL not be set.
REQ-029 overflow and underflow SHALL stay set until rst or clr.
REQ-030 clr SHALL have priority over we/re in its cycle: pointers 0, level 0, flags to reset values, dvalid 0, sticky errors cleared; array contents untouched.

Reset
REQ-031 rst SHALL asynchronously force: pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, dvalid 0, dout 0 when OREG=1.
REQ-032 With OREG=0, dout is don't-care while empty.
REQ-033 Assertion of rst mid-transfer SHALL discard all stored words; the first write after rst release SHALL land at address 0.

Verification (DATA_WIDTH=16, DATA_DEPTH=4, defaults unless noted)
REQ-034 Write 0x0001..0x0010 on consecutive cycles, then read 16: full rises after 16th write, almost_full at level 14, reads return 0x0001..0x0010 in order, empty after last, no error flags.
REQ-035 Fill to 16, then we&re for 20 cycles with incrementing data: level stays 16, output order preserved across pointer wrap, overflow 0.
REQ-036 Empty FIFO, we&re same cycle with 0xA5A5: underflow=1, level=1, dout=0xA5A5 with dvalid=1 next cycle (OREG=0).
REQ-037 Full FIFO, we=1 re=0 with 0xDEAD: overflow=1, level 16, 0xDEAD never read back; clr then clears overflow, level 0, empty 1.
REQ-038 OREG=1: write 0x1234, wait, pulse re: dout=0x1234 with dvalid=1 one cycle after re, dvalid=0 the following cycle, dout held.
REQ-039 Load 5 words, assert rst asynchronously between edges: all flags at reset values immediately; next write 0x00FF reads back as 0x00FF, level 1.
